pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the fetch front end: owns the 32-bit PC register and decides each cycle whether it holds, increments or loads a redirect target. Presents the PC to instruction fetch over a valid/ready handshake. Applies stall, halt and redirect requests from the core control path. Sits between core control and the instruction-memory request port.

## Interface
- PC_W, 32, PC width in bits
- RESET_PC, 32'h0000_0000, PC value after reset
- INCR, 4, PC increment per accepted fetch; also the alignment unit for redirect targets (power of two)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE; ignored in any other state
- stall  in  1  level request to pause fetch
- halt_req  in  1  request permanent stop until reset
- redirect_valid  in  1  load redirect_target into PC (branch/jump/flush)
- redirect_target  in  PC_W  new PC
- fetch_valid  out  1  fetch_addr is a valid request
- fetch_addr  out  PC_W  current PC
- fetch_ready  in  1  fetch port accepts the request
- fetch_count  out  16  accepted-fetch counter, wraps modulo 2^16
- halted  out  1  state is HALT
- misaligned_err  out  1  sticky: redirect_target not INCR-aligned

## Operation
- States:
  - IDLE: after reset.
  - RUN.
  - STALL.
  - HALT: terminal until reset.
- Outputs are Moore:
  - fetch_valid = (state == RUN).
  - fetch_addr = PC register.
  - halted = (state == HALT).
- Handshake: a fetch is accepted when fetch_valid & fetch_ready at a rising edge.
  - On acceptance: PC <= PC + INCR, truncated to PC_W (wraps to 0), and fetch_count += 1.
  - While fetch_valid & !fetch_ready, fetch_addr stays stable. The only exceptions are a redirect or a misaligned-error flush, which retract or replace the request.
- Priority per cycle, highest first:
  1. Misaligned redirect (target mod INCR != 0):
     - PC is not loaded and misaligned_err is set.
     - Next state is HALT from any state except HALT.
     - A coincident handshake is still counted.
  2. Aligned redirect: PC <= redirect_target, overriding the increment. State handling:
     - In RUN, state is kept, and a coincident handshake still increments fetch_count.
     - In IDLE or STALL, state is kept.
     - In HALT, the redirect is ignored.
  3. halt_req:
     - From IDLE or STALL: HALT at the next edge.
     - From RUN: HALT only when a handshake completes that cycle; otherwise stay in RUN with the request held.
  4. stall: RUN to STALL only at an accepting edge; without fetch_ready, stay in RUN with valid held. STALL with !stall returns to RUN.
  5. IDLE & start: go to RUN.
- halt_req and stall are level-sensitive. They take effect at the first eligible edge while high.

## Timing
- Reset values: state IDLE, PC = RESET_PC, fetch_valid 0, fetch_count 0, halted 0, misaligned_err 0.
- start sampled at edge n: fetch_valid is high in the cycle after edge n, with fetch_addr = PC.
- Throughput with fetch_ready held high: one fetch per cycle, addresses increment by INCR each cycle.
- Redirect sampled at edge n: fetch_addr = target in the following cycle (one-cycle latency).
- Stall released at edge n: fetch_valid is high after edge n, at the next sequential address.
- Misaligned redirect at edge n: fetch_valid 0, halted 1 and misaligned_err 1 after edge n.
- reset_n assertion mid-operation:
  - All state and outputs return to reset values immediately, with no clock needed.
  - An in-flight request is dropped.
  - Deassertion is clean only when synchronous to clk; this block does not synchronize it.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum (IDLE, RUN, STALL, HALT)
  - PC_W default
  - INCR default
  - RESET_PC default
- One natural sub-module, pc_next_sel: combinational priority/next-PC selection that outputs next_pc, pc_load and the alignment check.
- The state register, PC register and counter stay in pc_sequencer.

## Test plan
- Backpressure:
  - Stimulus: reset, start, fetch_ready=1 for 4 cycles; then fetch_ready=0 for 3 cycles.
  - Response: addresses 0x0, 0x4, 0x8, 0xC are accepted and fetch_count=4. fetch_addr then holds at 0x10 with fetch_valid=1 for 3 cycles.
- Redirect on accept:
  - Stimulus: redirect_valid with target 0x1000 in the same cycle as an accepting handshake at 0x10.
  - Response: next fetch_addr=0x1000 and fetch_count increments.
- Stall at handshake boundary:
  - Stimulus: stall=1 while fetch_ready=0 at 0x20; then fetch_ready=1.
  - Response: valid is held until 0x20 is accepted, then state is STALL with fetch_valid=0. Releasing stall resumes at 0x24.
- Misaligned redirect:
  - Stimulus: redirect to 0x1002 in RUN.
  - Response: misaligned_err=1, halted=1, fetch_valid=0, PC unchanged. Later redirects and start are ignored.
- Wrap:
  - Stimulus: redirect to 0xFFFF_FFFC, then accept.
  - Response: fetch_addr=0x0000_0000.
  - Stimulus: halt_req while in STALL.
  - Response: HALT on the next edge.
- Reset mid-run:
  - Stimulus: assert reset_n=0 between clock edges while fetch_valid=1.
  - Response: all outputs at reset values before the next edge. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and default parameters for the PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int              PC_W_DEFAULT     = 32;
  localparam int              INCR_DEFAULT     = 4;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority selection and redirect alignment check
import pc_seq_pkg::*;

module pc_next_sel #(
  parameter int PC_W = PC_W_DEFAULT,
  parameter int INCR = INCR_DEFAULT
) (
  input  state_t            state,
  input  logic [PC_W-1:0]   pc,
  input  logic              accept,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  output logic [PC_W-1:0]   next_pc,
  output logic              pc_load,
  output logic              misaligned
);

  logic active_redirect;
  logic target_unaligned;

  // Redirects are dead once halted; the error flag only reacts to live ones.
  assign active_redirect  = redirect_valid && (state != ST_HALT);
  assign target_unaligned = (redirect_target & PC_W'(INCR - 1)) != '0;
  assign misaligned       = active_redirect && target_unaligned;

  always_comb begin
    next_pc = pc;
    pc_load = 1'b0;
    if (misaligned) begin
      next_pc = pc;
      pc_load = 1'b0;
    end else if (active_redirect) begin
      next_pc = redirect_target;
      pc_load = 1'b1;
    end else if (accept) begin
      next_pc = pc + PC_W'(INCR);
      pc_load = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, fetch handshake FSM and accepted-fetch counter
import pc_seq_pkg::*;

module pc_sequencer #(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter int              INCR     = INCR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  output logic              fetch_valid,
  output logic [PC_W-1:0]   fetch_addr,
  input  logic              fetch_ready,
  output logic [15:0]       fetch_count,
  output logic              halted,
  output logic              misaligned_err
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic            pc_load;
  logic            misaligned;
  logic            accept;

  assign accept     = (state == ST_RUN) && fetch_ready;
  assign fetch_addr = pc;

  pc_next_sel #(
    .PC_W (PC_W),
    .INCR (INCR)
  ) u_next_sel (
    .state           (state),
    .pc              (pc),
    .accept          (accept),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .pc_load         (pc_load),
    .misaligned      (misaligned)
  );

  // Halt and stall leave RUN only on an accepting edge so a pending request is never retracted.
  always_comb begin
    state_nxt = state;
    if (misaligned) begin
      state_nxt = ST_HALT;
    end else if (!(redirect_valid && state != ST_HALT)) begin
      case (state)
        ST_IDLE: begin
          if (halt_req)   state_nxt = ST_HALT;
          else if (start) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            if (halt_req)   state_nxt = ST_HALT;
            else if (stall) state_nxt = ST_STALL;
          end
        end
        ST_STALL: begin
          if (halt_req)    state_nxt = ST_HALT;
          else if (!stall) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      fetch_count    <= 16'd0;
      fetch_valid    <= 1'b0;
      halted         <= 1'b0;
      misaligned_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_valid <= (state_nxt == ST_RUN);
      halted      <= (state_nxt == ST_HALT);
      if (pc_load)    pc             <= next_pc;
      if (accept)     fetch_count    <= fetch_count + 16'd1;
      if (misaligned) misaligned_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stall;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [15:0] fetch_count;
  logic        halted;
  logic        misaligned_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .stall           (stall),
    .halt_req        (halt_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_valid     (fetch_valid),
    .fetch_addr      (fetch_addr),
    .fetch_ready     (fetch_ready),
    .fetch_count     (fetch_count),
    .halted          (halted),
    .misaligned_err  (misaligned_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] a,
                           input logic [15:0] c, input logic h, input logic e);
    check({tag, "_valid"}, 32'(fetch_valid), 32'(v));
    check({tag, "_addr"}, fetch_addr, a);
    check({tag, "_count"}, 32'(fetch_count), 32'(c));
    check({tag, "_halted"}, 32'(halted), 32'(h));
    check({tag, "_err"}, 32'(misaligned_err), 32'(e));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; fetch_ready = 1'b0;
    #1;
    check_all("reset", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;

    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("start", 1'b1, 32'h0, 16'd0, 1'b0, 1'b0);

    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_addr%0d", i), fetch_addr, 32'(i * 4));
      tick();
    end
    fetch_ready = 1'b0;
    check("bp_count", 32'(fetch_count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_valid%0d", i), 32'(fetch_valid), 32'd1);
      check($sformatf("hold_addr%0d", i), fetch_addr, 32'h10);
    end

    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1000;
    tick();
    check_all("redir_acc", 1'b1, 32'h1000, 16'd5, 1'b0, 1'b0);

    fetch_ready = 1'b0; redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    check_all("redir_idle", 1'b1, 32'h20, 16'd5, 1'b0, 1'b0);

    stall = 1'b1;
    tick();
    check_all("stall_wait", 1'b1, 32'h20, 16'd5, 1'b0, 1'b0);
    fetch_ready = 1'b1;
    tick();
    check_all("stall_enter", 1'b0, 32'h24, 16'd6, 1'b0, 1'b0);
    tick();
    check_all("stall_hold", 1'b0, 32'h24, 16'd6, 1'b0, 1'b0);
    stall = 1'b0; fetch_ready = 1'b0;
    tick();
    check_all("stall_release", 1'b1, 32'h24, 16'd6, 1'b0, 1'b0);

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_target", fetch_addr, 32'hFFFF_FFFC);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check_all("wrap", 1'b1, 32'h0, 16'd7, 1'b0, 1'b0);

    stall = 1'b1; fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check_all("stall2", 1'b0, 32'h4, 16'd8, 1'b0, 1'b0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; stall = 1'b0;
    check_all("halt_from_stall", 1'b0, 32'h4, 16'd8, 1'b1, 1'b0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check_all("rerun", 1'b1, 32'h4, 16'd1, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check_all("idle_after_reset", 1'b0, 32'h0, 16'd0, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("start2", 1'b1, 32'h0, 16'd0, 1'b0, 1'b0);
    redirect_valid = 1'b1; redirect_target = 32'h1002; fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check_all("misaligned", 1'b0, 32'h0, 16'd1, 1'b1, 1'b1);
    redirect_target = 32'h2000; start = 1'b1;
    tick(); tick();
    redirect_valid = 1'b0; start = 1'b0;
    check_all("halt_sticky", 1'b0, 32'h0, 16'd1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
